// File: rtl/commit_stage_mp.sv
`default_nettype none
// ============================================================================
// commit_stage_mp : multi-port in-order commit stage with fence/AMO sequencer
// Revision 1.0
// ============================================================================
module commit_stage_mp #(
  parameter int NR_PORTS      = 2,
  parameter int XLEN          = 64,
  parameter int DRAIN_TIMEOUT = 1024,
  parameter int CNT_W         = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     halt_i,
  input  logic                     single_step_i,
  input  logic [NR_PORTS-1:0]      instr_valid_i,
  input  logic [NR_PORTS-1:0]      instr_ex_i,
  input  logic [NR_PORTS*XLEN-1:0] instr_cause_i,
  input  logic [NR_PORTS*3-1:0]    instr_kind_i,
  input  logic [NR_PORTS-1:0]      instr_fpr_i,
  input  logic [NR_PORTS*5-1:0]    instr_rd_i,
  input  logic [NR_PORTS*XLEN-1:0] instr_result_i,
  input  logic [NR_PORTS*5-1:0]    instr_fflags_i,
  output logic [NR_PORTS-1:0]      commit_ack_o,
  output logic [NR_PORTS-1:0]      we_gpr_o,
  output logic [NR_PORTS-1:0]      we_fpr_o,
  output logic [NR_PORTS*5-1:0]    waddr_o,
  output logic [NR_PORTS*XLEN-1:0] wdata_o,
  output logic                     commit_lsu_o,
  input  logic                     commit_lsu_ready_i,
  input  logic                     no_st_pending_i,
  input  logic [XLEN-1:0]          csr_rdata_i,
  input  logic                     csr_exception_i,
  output logic                     commit_csr_o,
  output logic                     fflags_we_o,
  output logic [4:0]               fflags_o,
  output logic                     fence_o,
  output logic                     fence_i_o,
  output logic                     sfence_vma_o,
  input  logic                     flush_done_i,
  output logic                     amo_valid_commit_o,
  input  logic                     amo_ack_i,
  input  logic [XLEN-1:0]          amo_result_i,
  output logic                     exception_valid_o,
  output logic [XLEN-1:0]          exception_cause_o,
  output logic                     drain_timeout_o,
  output logic [CNT_W-1:0]         retire_cnt_o
);

  localparam logic [2:0] C_KIND_ALU    = 3'd0;
  localparam logic [2:0] C_KIND_STORE  = 3'd1;
  localparam logic [2:0] C_KIND_CSR    = 3'd2;
  localparam logic [2:0] C_KIND_FENCE  = 3'd3;
  localparam logic [2:0] C_KIND_FENCEI = 3'd4;
  localparam logic [2:0] C_KIND_SFENCE = 3'd5;
  localparam logic [2:0] C_KIND_AMO    = 3'd6;
  localparam logic [2:0] C_KIND_FPU    = 3'd7;

  localparam int                C_DCNT_W     = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [C_DCNT_W-1:0] C_DRAIN_MAX  = C_DCNT_W'(DRAIN_TIMEOUT);
  localparam logic [C_DCNT_W-1:0] C_DRAIN_LAST = C_DCNT_W'(DRAIN_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DRAIN     = 3'd1,
    S_FLUSH     = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_AMO_WAIT  = 3'd4
  } state_t;

  state_t              r_state;
  logic [2:0]          r_flush_kind;
  logic [C_DCNT_W-1:0] r_drain_cnt;
  logic                r_drain_timeout;
  logic [CNT_W-1:0]    r_retire_cnt;

  logic       w_idle;
  logic       w_head_ok;
  logic       w_prev_ack;
  logic [2:0] w_kind0;

  assign w_idle          = (r_state == S_IDLE);
  assign w_kind0         = instr_kind_i[2:0];
  assign w_head_ok       = instr_valid_i[0] && !instr_ex_i[0] && !halt_i;
  assign waddr_o         = instr_rd_i;
  assign drain_timeout_o = r_drain_timeout;
  assign retire_cnt_o    = r_retire_cnt;

  generate
    if (NR_PORTS > 1) begin : g_unused_cause
      logic w_unused_cause;
      assign w_unused_cause = ^instr_cause_i[NR_PORTS*XLEN-1:XLEN];
    end
  endgenerate

  always_comb begin
    commit_ack_o       = '0;
    we_gpr_o           = '0;
    we_fpr_o           = '0;
    wdata_o            = instr_result_i;
    commit_lsu_o       = 1'b0;
    commit_csr_o       = 1'b0;
    amo_valid_commit_o = 1'b0;
    exception_valid_o  = 1'b0;
    exception_cause_o  = '0;
    fflags_we_o        = 1'b0;
    fflags_o           = '0;
    fence_o            = (r_state == S_FLUSH) && (r_flush_kind == C_KIND_FENCE);
    fence_i_o          = (r_state == S_FLUSH) && (r_flush_kind == C_KIND_FENCEI);
    sfence_vma_o       = (r_state == S_FLUSH) && (r_flush_kind == C_KIND_SFENCE);
    w_prev_ack         = 1'b0;

    if (w_idle && instr_valid_i[0] && !halt_i) begin
      if (instr_ex_i[0]) begin
        exception_valid_o = 1'b1;
        exception_cause_o = instr_cause_i[XLEN-1:0];
      end else begin
        case (w_kind0)
          C_KIND_ALU, C_KIND_FPU: begin
            commit_ack_o[0] = 1'b1;
            if (instr_fpr_i[0]) we_fpr_o[0] = 1'b1;
            else                we_gpr_o[0] = 1'b1;
          end
          C_KIND_STORE: begin
            commit_lsu_o    = commit_lsu_ready_i;
            commit_ack_o[0] = commit_lsu_ready_i;
          end
          C_KIND_CSR: begin
            if (!csr_exception_i) begin
              commit_ack_o[0]       = 1'b1;
              commit_csr_o          = 1'b1;
              we_gpr_o[0]           = 1'b1;
              wdata_o[XLEN-1:0]     = csr_rdata_i;
            end else begin
              exception_valid_o = 1'b1;
              exception_cause_o = XLEN'(2);
            end
          end
          C_KIND_AMO: amo_valid_commit_o = 1'b1;
          default: ;
        endcase
      end
    end

    if (r_state == S_WAIT_DONE && flush_done_i) begin
      commit_ack_o[0] = 1'b1;
    end

    if (r_state == S_AMO_WAIT) begin
      amo_valid_commit_o = 1'b1;
      if (amo_ack_i) begin
        commit_ack_o[0]   = 1'b1;
        we_gpr_o[0]       = 1'b1;
        wdata_o[XLEN-1:0] = amo_result_i;
      end
    end

    // Younger ports only retire behind an unbroken chain of acks from port0
    w_prev_ack = commit_ack_o[0];
    for (int k = 1; k < NR_PORTS; k++) begin
      if (w_prev_ack && w_idle && (w_kind0 != C_KIND_CSR) && !halt_i && !single_step_i &&
          instr_valid_i[k] && !instr_ex_i[k] &&
          ((instr_kind_i[3*k +: 3] == C_KIND_ALU) || (instr_kind_i[3*k +: 3] == C_KIND_FPU))) begin
        commit_ack_o[k] = 1'b1;
        if (instr_fpr_i[k]) we_fpr_o[k] = 1'b1;
        else                we_gpr_o[k] = 1'b1;
      end
      w_prev_ack = commit_ack_o[k];
    end

    if (rst_i) begin
      commit_ack_o = '0;
      we_gpr_o     = '0;
      we_fpr_o     = '0;
      commit_lsu_o = 1'b0;
      commit_csr_o = 1'b0;
    end

    for (int k = 0; k < NR_PORTS; k++) begin
      if (commit_ack_o[k] && (instr_kind_i[3*k +: 3] == C_KIND_FPU)) begin
        fflags_we_o = 1'b1;
        fflags_o    = fflags_o | instr_fflags_i[5*k +: 5];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state         <= S_IDLE;
      r_flush_kind    <= C_KIND_ALU;
      r_drain_cnt     <= '0;
      r_drain_timeout <= 1'b0;
      r_retire_cnt    <= '0;
    end else begin
      r_retire_cnt <= r_retire_cnt + CNT_W'($countones(commit_ack_o));
      case (r_state)
        S_IDLE: begin
          if (w_head_ok) begin
            if ((w_kind0 == C_KIND_FENCE) || (w_kind0 == C_KIND_FENCEI) ||
                (w_kind0 == C_KIND_SFENCE)) begin
              r_state      <= S_DRAIN;
              r_flush_kind <= w_kind0;
              r_drain_cnt  <= '0;
            end else if (w_kind0 == C_KIND_AMO) begin
              r_state <= S_AMO_WAIT;
            end
          end
        end
        S_DRAIN: begin
          if (no_st_pending_i) begin
            r_state     <= S_FLUSH;
            r_drain_cnt <= '0;
          end else begin
            // Counter saturates; the watchdog flag only reports, it never aborts the fence
            if (r_drain_cnt != C_DRAIN_MAX) r_drain_cnt <= r_drain_cnt + 1'b1;
            if (r_drain_cnt >= C_DRAIN_LAST) r_drain_timeout <= 1'b1;
          end
        end
        S_FLUSH:     r_state <= S_WAIT_DONE;
        S_WAIT_DONE: if (flush_done_i) r_state <= S_IDLE;
        S_AMO_WAIT:  if (amo_ack_i) r_state <= S_IDLE;
        default:     r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_commit_stage_mp.sv
`default_nettype none
// ============================================================================
// tb_commit_stage_mp : directed self-checking bench for commit_stage_mp
// Revision 1.0
// ============================================================================
module tb_commit_stage_mp;
  localparam int NP = 2;
  localparam int XL = 64;
  localparam int DT = 4;
  localparam int CW = 4;

  localparam logic [2:0] K_ALU = 3'd0, K_STORE = 3'd1, K_CSR = 3'd2, K_FENCE = 3'd3;
  localparam logic [2:0] K_FENCEI = 3'd4, K_AMO = 3'd6, K_FPU = 3'd7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic halt, sstep;
  logic [NP-1:0] valid, ex, fpr;
  logic [NP*XL-1:0] cause, result;
  logic [NP*3-1:0] kind;
  logic [NP*5-1:0] rd, fflags_in;
  logic lsu_ready, no_st_pending, csr_exc, flush_done, amo_ack;
  logic [XL-1:0] csr_rdata, amo_result;

  logic [NP-1:0] commit_ack, we_gpr, we_fpr;
  logic [NP*5-1:0] waddr;
  logic [NP*XL-1:0] wdata;
  logic commit_lsu, commit_csr, fflags_we, fence, fence_i, sfence, amo_valid, exc_valid, drain_to;
  logic [4:0] fflags_out;
  logic [XL-1:0] exc_cause;
  logic [CW-1:0] retire_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  commit_stage_mp #(.NR_PORTS(NP), .XLEN(XL), .DRAIN_TIMEOUT(DT), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst), .halt_i(halt), .single_step_i(sstep),
    .instr_valid_i(valid), .instr_ex_i(ex), .instr_cause_i(cause), .instr_kind_i(kind),
    .instr_fpr_i(fpr), .instr_rd_i(rd), .instr_result_i(result), .instr_fflags_i(fflags_in),
    .commit_ack_o(commit_ack), .we_gpr_o(we_gpr), .we_fpr_o(we_fpr), .waddr_o(waddr),
    .wdata_o(wdata), .commit_lsu_o(commit_lsu), .commit_lsu_ready_i(lsu_ready),
    .no_st_pending_i(no_st_pending), .csr_rdata_i(csr_rdata), .csr_exception_i(csr_exc),
    .commit_csr_o(commit_csr), .fflags_we_o(fflags_we), .fflags_o(fflags_out),
    .fence_o(fence), .fence_i_o(fence_i), .sfence_vma_o(sfence), .flush_done_i(flush_done),
    .amo_valid_commit_o(amo_valid), .amo_ack_i(amo_ack), .amo_result_i(amo_result),
    .exception_valid_o(exc_valid), .exception_cause_o(exc_cause),
    .drain_timeout_o(drain_to), .retire_cnt_o(retire_cnt)
  );

  task automatic clear_inputs();
    halt = 0; sstep = 0; valid = '0; ex = '0; fpr = '0; cause = '0; result = '0;
    kind = '0; rd = '0; fflags_in = '0; lsu_ready = 0; no_st_pending = 1; csr_exc = 0;
    flush_done = 0; amo_ack = 0; csr_rdata = '0; amo_result = '0;
  endtask

  task automatic set_entry(input int p, input logic [2:0] k, input logic f,
                           input logic [4:0] r, input logic [XL-1:0] res);
    valid[p] = 1'b1; ex[p] = 1'b0; kind[3*p +: 3] = k; fpr[p] = f;
    rd[5*p +: 5] = r; result[XL*p +: XL] = res;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1; clear_inputs();
    @(negedge clk); rst = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    set_entry(0, K_ALU, 0, 5'd3, 64'h1); set_entry(1, K_ALU, 0, 5'd4, 64'h2);
    @(negedge clk); #1;
    n_cmp++; if (commit_ack !== 2'b00) begin n_bad++; $display("FAIL reset_ack_prio: got %b want 00", commit_ack); end
    @(negedge clk); #1;
    n_cmp++; if (retire_cnt !== 4'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", retire_cnt); end
    n_cmp++; if (drain_to !== 1'b0) begin n_bad++; $display("FAIL reset_timeout: got %b want 0", drain_to); end
    rst = 0; clear_inputs();
    @(negedge clk); #1;
    n_cmp++; if ({commit_ack, fence, fence_i, sfence, amo_valid, exc_valid, commit_lsu} !== 8'd0) begin
      n_bad++; $display("FAIL reset_idle_outs: got %b want 0", {commit_ack, fence, fence_i, sfence, amo_valid, exc_valid, commit_lsu}); end
  endtask

  task automatic test_dual_alu();
    @(negedge clk); clear_inputs();
    set_entry(0, K_ALU, 0, 5'd3, 64'h11); set_entry(1, K_ALU, 0, 5'd4, 64'h22); #1;
    n_cmp++; if (commit_ack !== 2'b11) begin n_bad++; $display("FAIL dual_ack: got %b want 11", commit_ack); end
    n_cmp++; if (we_gpr !== 2'b11 || we_fpr !== 2'b00) begin n_bad++; $display("FAIL dual_we: got gpr %b fpr %b want 11/00", we_gpr, we_fpr); end
    n_cmp++; if (waddr !== {5'd4, 5'd3}) begin n_bad++; $display("FAIL dual_waddr: got %h want %h", waddr, {5'd4, 5'd3}); end
    n_cmp++; if (wdata !== {64'h22, 64'h11}) begin n_bad++; $display("FAIL dual_wdata: got %h want 22/11", wdata); end
    @(negedge clk); clear_inputs(); #1;
    n_cmp++; if (retire_cnt !== 4'd2) begin n_bad++; $display("FAIL dual_cnt: got %0d want 2", retire_cnt); end
  endtask

  task automatic test_store();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); clear_inputs();
      set_entry(0, K_STORE, 0, 5'd0, 64'h0); set_entry(1, K_ALU, 0, 5'd5, 64'h55);
      lsu_ready = (i == 3); #1;
      if (i < 3) begin
        n_cmp++; if (commit_ack !== 2'b00 || commit_lsu !== 1'b0) begin
          n_bad++; $display("FAIL store_wait%0d: got ack %b lsu %b want 00/0", i, commit_ack, commit_lsu); end
      end else begin
        n_cmp++; if (commit_ack !== 2'b11 || commit_lsu !== 1'b1) begin
          n_bad++; $display("FAIL store_go: got ack %b lsu %b want 11/1", commit_ack, commit_lsu); end
        n_cmp++; if (we_gpr !== 2'b10) begin n_bad++; $display("FAIL store_we: got %b want 10", we_gpr); end
      end
    end
    @(negedge clk); clear_inputs(); #1;
    n_cmp++; if (retire_cnt !== 4'd4) begin n_bad++; $display("FAIL store_cnt: got %0d want 4", retire_cnt); end
  endtask

  task automatic test_fpu();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); clear_inputs();
      set_entry(0, K_FPU, 1, 5'd1, 64'hA); set_entry(1, K_FPU, 0, 5'd2, 64'hB);
      fflags_in = {5'b10000, 5'b00001};
      halt = (i == 1); sstep = (i == 2); #1;
      if (i == 0) begin
        n_cmp++; if (commit_ack !== 2'b11 || we_fpr !== 2'b01 || we_gpr !== 2'b10) begin
          n_bad++; $display("FAIL fpu_we: got ack %b fpr %b gpr %b want 11/01/10", commit_ack, we_fpr, we_gpr); end
        n_cmp++; if (fflags_we !== 1'b1 || fflags_out !== 5'b10001) begin
          n_bad++; $display("FAIL fpu_flags: got %b/%b want 1/10001", fflags_we, fflags_out); end
      end else if (i == 1) begin
        n_cmp++; if (commit_ack !== 2'b00 || fflags_we !== 1'b0) begin
          n_bad++; $display("FAIL fpu_halt: got ack %b fwe %b want 00/0", commit_ack, fflags_we); end
      end else begin
        n_cmp++; if (commit_ack !== 2'b01 || fflags_out !== 5'b00001) begin
          n_bad++; $display("FAIL fpu_sstep: got ack %b flags %b want 01/00001", commit_ack, fflags_out); end
      end
    end
    @(negedge clk); clear_inputs(); #1;
    n_cmp++; if (retire_cnt !== 4'd7) begin n_bad++; $display("FAIL fpu_cnt: got %0d want 7", retire_cnt); end
  endtask

  task automatic test_csr();
    @(negedge clk); clear_inputs();
    set_entry(0, K_CSR, 0, 5'd9, 64'h0); set_entry(1, K_ALU, 0, 5'd6, 64'h66);
    csr_rdata = 64'hABC; #1;
    n_cmp++; if (commit_ack !== 2'b01 || commit_csr !== 1'b1 || we_gpr !== 2'b01) begin
      n_bad++; $display("FAIL csr_ok: got ack %b csr %b gpr %b want 01/1/01", commit_ack, commit_csr, we_gpr); end
    n_cmp++; if (wdata[XL-1:0] !== 64'hABC) begin n_bad++; $display("FAIL csr_wdata: got %h want abc", wdata[XL-1:0]); end
    @(negedge clk); csr_exc = 1; #1;
    n_cmp++; if (commit_ack !== 2'b00 || commit_csr !== 1'b0) begin
      n_bad++; $display("FAIL csr_fault_ack: got ack %b csr %b want 00/0", commit_ack, commit_csr); end
    n_cmp++; if (exc_valid !== 1'b1 || exc_cause !== 64'd2) begin
      n_bad++; $display("FAIL csr_fault_exc: got %b/%0d want 1/2", exc_valid, exc_cause); end
    @(negedge clk); clear_inputs(); #1;
    n_cmp++; if (retire_cnt !== 4'd8) begin n_bad++; $display("FAIL csr_cnt: got %0d want 8", retire_cnt); end
  endtask

  task automatic test_fence();
    for (int c = 0; c < 9; c++) begin
      @(negedge clk); clear_inputs();
      set_entry(0, K_FENCE, 0, 5'd0, 64'h0); set_entry(1, K_ALU, 0, 5'd7, 64'h77);
      no_st_pending = (c >= 5); flush_done = (c == 8); #1;
      if (c < 6) begin
        n_cmp++; if (fence !== 1'b0 || commit_ack !== 2'b00) begin
          n_bad++; $display("FAIL fence_pre%0d: got fence %b ack %b want 0/00", c, fence, commit_ack); end
      end else if (c == 6) begin
        n_cmp++; if ({fence, fence_i, sfence} !== 3'b100) begin
          n_bad++; $display("FAIL fence_pulse: got %b want 100", {fence, fence_i, sfence}); end
      end else if (c == 7) begin
        n_cmp++; if (fence !== 1'b0 || commit_ack !== 2'b00) begin
          n_bad++; $display("FAIL fence_wait: got fence %b ack %b want 0/00", fence, commit_ack); end
      end else begin
        n_cmp++; if (commit_ack !== 2'b01) begin n_bad++; $display("FAIL fence_ack: got %b want 01", commit_ack); end
      end
    end
    @(negedge clk); clear_inputs(); #1;
    n_cmp++; if (retire_cnt !== 4'd9) begin n_bad++; $display("FAIL fence_cnt: got %0d want 9", retire_cnt); end
    n_cmp++; if (drain_to !== 1'b1) begin n_bad++; $display("FAIL fence_timeout: got %b want 1", drain_to); end
  endtask

  task automatic test_drain_timeout();
    do_reset();
    for (int c = 0; c < 12; c++) begin
      @(negedge clk); clear_inputs();
      set_entry(0, K_FENCEI, 0, 5'd0, 64'h0);
      no_st_pending = (c >= 9); flush_done = (c == 11); #1;
      if (c == 4) begin
        n_cmp++; if (drain_to !== 1'b0) begin n_bad++; $display("FAIL to_early: got %b want 0", drain_to); end
      end else if (c >= 5 && c <= 9) begin
        n_cmp++; if (drain_to !== 1'b1) begin n_bad++; $display("FAIL to_set%0d: got %b want 1", c, drain_to); end
      end else if (c == 10) begin
        n_cmp++; if ({fence, fence_i, sfence} !== 3'b010) begin
          n_bad++; $display("FAIL to_fencei: got %b want 010", {fence, fence_i, sfence}); end
      end else if (c == 11) begin
        n_cmp++; if (commit_ack !== 2'b01) begin n_bad++; $display("FAIL to_ack: got %b want 01", commit_ack); end
      end
    end
    @(negedge clk); clear_inputs(); #1;
    n_cmp++; if (drain_to !== 1'b1 || retire_cnt !== 4'd1) begin
      n_bad++; $display("FAIL to_sticky: got %b cnt %0d want 1/1", drain_to, retire_cnt); end
    do_reset(); #1;
    n_cmp++; if (drain_to !== 1'b0 || retire_cnt !== 4'd0) begin
      n_bad++; $display("FAIL to_clear: got %b cnt %0d want 0/0", drain_to, retire_cnt); end
  endtask

  task automatic test_exception();
    @(negedge clk); clear_inputs();
    set_entry(0, K_ALU, 0, 5'd1, 64'h1); set_entry(1, K_ALU, 0, 5'd2, 64'h2);
    ex[0] = 1'b1; cause[XL-1:0] = 64'd13; #1;
    n_cmp++; if (exc_valid !== 1'b1 || exc_cause !== 64'd13) begin
      n_bad++; $display("FAIL exc_take: got %b/%0d want 1/13", exc_valid, exc_cause); end
    n_cmp++; if (commit_ack !== 2'b00) begin n_bad++; $display("FAIL exc_ack: got %b want 00", commit_ack); end
    @(negedge clk); halt = 1; #1;
    n_cmp++; if (exc_valid !== 1'b0 || commit_ack !== 2'b00) begin
      n_bad++; $display("FAIL exc_halt: got %b ack %b want 0/00", exc_valid, commit_ack); end
  endtask

  task automatic test_amo();
    for (int c = 0; c < 9; c++) begin
      @(negedge clk); clear_inputs();
      set_entry(0, K_AMO, 0, 5'd7, 64'h0); set_entry(1, K_ALU, 0, 5'd8, 64'h88);
      amo_ack = (c == 8); amo_result = 64'hDEAD; #1;
      if (c < 8) begin
        n_cmp++; if (amo_valid !== 1'b1 || commit_ack !== 2'b00) begin
          n_bad++; $display("FAIL amo_wait%0d: got valid %b ack %b want 1/00", c, amo_valid, commit_ack); end
      end else begin
        n_cmp++; if (commit_ack !== 2'b01 || we_gpr !== 2'b01) begin
          n_bad++; $display("FAIL amo_ack: got ack %b gpr %b want 01/01", commit_ack, we_gpr); end
        n_cmp++; if (wdata[XL-1:0] !== 64'hDEAD || waddr[4:0] !== 5'd7) begin
          n_bad++; $display("FAIL amo_wdata: got %h rd %0d want dead/7", wdata[XL-1:0], waddr[4:0]); end
      end
    end
    @(negedge clk); clear_inputs(); #1;
    n_cmp++; if (retire_cnt !== 4'd1 || amo_valid !== 1'b0) begin
      n_bad++; $display("FAIL amo_done: got cnt %0d valid %b want 1/0", retire_cnt, amo_valid); end
  endtask

  task automatic test_reset_wait_done();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); clear_inputs();
      set_entry(0, K_FENCE, 0, 5'd0, 64'h0);
      rst = (c == 3); flush_done = (c >= 3); #1;
      if (c == 2) begin
        n_cmp++; if (fence !== 1'b1) begin n_bad++; $display("FAIL rwd_fence: got %b want 1", fence); end
      end else if (c == 3) begin
        n_cmp++; if (commit_ack !== 2'b00) begin n_bad++; $display("FAIL rwd_rst_ack: got %b want 00", commit_ack); end
      end else if (c == 4) begin
        n_cmp++; if (commit_ack !== 2'b00 || fence !== 1'b0 || retire_cnt !== 4'd0) begin
          n_bad++; $display("FAIL rwd_after: got ack %b fence %b cnt %0d want 00/0/0", commit_ack, fence, retire_cnt); end
      end
    end
    do_reset();
  endtask

  task automatic test_wrap();
    for (int c = 0; c < 9; c++) begin
      @(negedge clk); clear_inputs();
      set_entry(0, K_ALU, 0, 5'd1, 64'h1); set_entry(1, K_ALU, 0, 5'd2, 64'h2); #1;
      if (c == 7) begin
        n_cmp++; if (retire_cnt !== 4'd14) begin n_bad++; $display("FAIL wrap_pre: got %0d want 14", retire_cnt); end
      end else if (c == 8) begin
        n_cmp++; if (retire_cnt !== 4'd0) begin n_bad++; $display("FAIL wrap_zero: got %0d want 0", retire_cnt); end
      end
    end
    @(negedge clk); clear_inputs(); #1;
    n_cmp++; if (retire_cnt !== 4'd2) begin n_bad++; $display("FAIL wrap_post: got %0d want 2", retire_cnt); end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_dual_alu();
    test_store();
    test_fpu();
    test_csr();
    test_fence();
    test_drain_timeout();
    test_exception();
    test_amo();
    test_reset_wait_done();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/commit_stage_mp.md
Name: commit_stage_mp

Overview:
- Parametrised multi-port commit stage; successor to the single-FSM-less commit logic.
- Retires up to NR_PORTS in-order scoreboard entries per cycle and writes GPR/FPR.
- Sequences fence, fence.i, sfence.vma and AMO through an explicit registered FSM with store-drain watchdog.
- Keeps a registered retire counter for CSR minstret.

Parameters:
NR_PORTS, 2, commit ports (1..4)
XLEN, 64, data width
DRAIN_TIMEOUT, 1024, max cycles in DRAIN before drain_timeout_o (>=2)
CNT_W, 64, retire counter width

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
halt_i  in  1  halt request; blocks all commits/exceptions
single_step_i  in  1  debug single-step; ports>0 never commit
instr_valid_i  in  NR_PORTS  entry valid
instr_ex_i  in  NR_PORTS  entry carries exception
instr_cause_i  in  NR_PORTS*XLEN  exception cause
instr_kind_i  in  NR_PORTS*3  0 ALU/LOAD/MUL/CTRL, 1 STORE, 2 CSR, 3 FENCE, 4 FENCE_I, 5 SFENCE_VMA, 6 AMO, 7 FPU
instr_fpr_i  in  NR_PORTS  rd is FP register
instr_rd_i  in  NR_PORTS*5  destination
instr_result_i  in  NR_PORTS*XLEN  result
instr_fflags_i  in  NR_PORTS*5  FP flags
commit_ack_o  out  NR_PORTS  entry retired this cycle
we_gpr_o / we_fpr_o  out  NR_PORTS each  regfile write enables
waddr_o  out  NR_PORTS*5  = instr_rd_i
wdata_o  out  NR_PORTS*XLEN  write data
commit_lsu_o  out  1  commit store
commit_lsu_ready_i  in  1  store buffer ready
no_st_pending_i  in  1  store buffer empty
csr_rdata_i  in  XLEN  CSR read data
csr_exception_i  in  1  CSR op faults
commit_csr_o  out  1  commit CSR op
fflags_we_o  out  1  write fflags
fflags_o  out  5  OR of committing FPU flags
fence_o / fence_i_o / sfence_vma_o  out  1 each  single-cycle flush requests
flush_done_i  in  1  controller finished flush
amo_valid_commit_o  out  1  AMO at head
amo_ack_i  in  1  AMO complete
amo_result_i  in  XLEN  AMO result
exception_valid_o  out  1  take trap
exception_cause_o  out  XLEN  cause
drain_timeout_o  out  1  sticky watchdog flag
retire_cnt_o  out  CNT_W  retired-instruction count

Behaviour:
- Reset (sync, rst_i=1): FSM IDLE, retire_cnt_o=0, drain counter=0, drain_timeout_o=0; all comb outputs 0 when inputs idle. Reset mid-FSM aborts to IDLE; no ack issued.
- FSM states: IDLE, DRAIN, FLUSH, WAIT_DONE, AMO_WAIT.
- IDLE, port0 valid, !ex, !halt:
  - ALU/FPU: ack same cycle; we_fpr if instr_fpr_i else we_gpr; wdata=result.
  - STORE: ack=commit_lsu_o=commit_lsu_ready_i; no regfile write.
  - CSR: if !csr_exception_i: ack, commit_csr_o, we_gpr, wdata=csr_rdata_i. Else no ack, no write.
  - FENCE/FENCE_I/SFENCE_VMA: no ack; next DRAIN.
  - AMO: amo_valid_commit_o=1; next AMO_WAIT.
- DRAIN: increment drain counter; when no_st_pending_i=1, next FLUSH and clear counter. If counter reaches DRAIN_TIMEOUT, set drain_timeout_o (sticky until reset); FSM keeps waiting.
- FLUSH: one-cycle pulse on fence_o, fence_i_o or sfence_vma_o per kind; next WAIT_DONE.
- WAIT_DONE: on flush_done_i, ack port0 that cycle, next IDLE.
- AMO_WAIT: amo_valid_commit_o=1. On amo_ack_i: ack, we_gpr, wdata=amo_result_i, next IDLE.
- FSM-owned ack is port0 only; ports>0 acks stay 0 outside IDLE.
- Port k>0 commits iff all of:
  - FSM IDLE; ports 0..k-1 acked this cycle; port0 kind not CSR.
  - !halt_i, !single_step_i; port k valid, !ex.
  - kind in {ALU, FPU}.
  - Writes as for port0 ALU/FPU.
- FPU: fflags_we_o=1 if any acked port is FPU; fflags_o=OR of those ports' flags.
- Exception: exception_valid_o=1 iff port0 valid, FSM IDLE, !halt_i, and (instr_ex_i[0] or port0 CSR with csr_exception_i).
  - cause = instr_cause_i[0] if instr_ex_i[0], else 2 (illegal instr).
  - Faulting entry not acked.
- Retire count: retire_cnt_o += popcount(commit_ack_o) at the clock edge; wraps modulo 2^CNT_W.
- Reset has priority over any same-cycle ack; no count increment.

Test Plan:
- Two valid ALU entries, rd 3/4, results 0x11/0x22 -> both acked same cycle; we_gpr=11; retire_cnt 0->2.
- Port0 STORE, commit_lsu_ready_i=0 for 3 cycles then 1 -> no ack for 3 cycles; ack+commit_lsu_o on 4th; port1 ALU acks same cycle.
- Port0 FENCE, no_st_pending_i low 5 cycles -> DRAIN 5 cycles, fence_o pulses exactly 1 cycle, ack on flush_done_i cycle; count +1.
- DRAIN_TIMEOUT=4, no_st_pending_i held 0 -> drain_timeout_o=1 after 4 DRAIN cycles; stays set; clears only on rst_i.
- Port0 AMO, amo_ack_i after 7 cycles, amo_result_i=0xDEAD -> ack, we_gpr, wdata=0xDEAD; port1 ALU not acked.
- Port0 ex, cause 13, halt_i=0 -> exception_valid_o=1, cause 13, no acks. Same with halt_i=1 -> exception_valid_o=0. Reset in WAIT_DONE -> IDLE, no ack, count 0.
